fetch_pc_gen: RTL and testbench

Fetch-stage next-PC generator. It sits directly upstream of the BTB and drives its pc_i, then consumes the BTB hit, target and way outputs in the same cycle. It qualifies each BTB hit with a bimodal table of 2-bit saturating counters, holds the PC register, and applies redirects from the execute stage on a mispredict. The prediction it makes for each fetched PC is passed down the pipeline for later resolution.

---
 rtl/fetch_pc_gen.sv | 89 ++++++++
 tb/tb_fetch_pc_gen.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/fetch_pc_gen.sv
// Fetch-stage next-PC generator: PC register, BTB-hit qualification and redirect handling.
// Define BHT_EN to qualify BTB hits with a bimodal table of 2-bit counters.
module fetch_pc_gen #(
  parameter int unsigned           ADDR_WIDTH  = 64,
  parameter logic [ADDR_WIDTH-1:0] RESET_ADDR  = '0,
  parameter int unsigned           BHT_ENTRIES = 64,
  parameter int unsigned           WAY_WIDTH   = 2
) (
  input  logic                  clk_i,
  input  logic                  arst_i,
  input  logic                  stall_fetch_i,
  input  logic                  redirect_i,
  input  logic [ADDR_WIDTH-1:0] redirect_addr_i,
  input  logic                  btb_hit_i,
  input  logic [ADDR_WIDTH-1:0] btb_target_i,
  input  logic [WAY_WIDTH-1:0]  btb_way_i,
  input  logic                  upd_en_i,
  input  logic [ADDR_WIDTH-1:0] upd_pc_i,
  input  logic                  upd_taken_i,
  output logic [ADDR_WIDTH-1:0] pc_o,
  output logic [ADDR_WIDTH-1:0] pc_plus4_o,
  output logic                  fetch_valid_o,
  output logic                  pred_taken_o,
  output logic [ADDR_WIDTH-1:0] pred_target_o,
  output logic [WAY_WIDTH-1:0]  pred_way_o
);

  localparam int unsigned IDX_W = $clog2(BHT_ENTRIES);

  logic pred_taken;

  assign pc_plus4_o    = pc_o + ADDR_WIDTH'(4);
  assign pred_taken_o  = pred_taken;
  assign pred_target_o = pred_taken ? btb_target_i : pc_plus4_o;
  assign pred_way_o    = btb_way_i;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values, independent of block ordering.
  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i) begin
      pc_o          <= RESET_ADDR;
      fetch_valid_o <= 1'b0;
    end else begin
      fetch_valid_o <= 1'b1;
      if (redirect_i) begin
        pc_o <= redirect_addr_i;
      end else if (!stall_fetch_i) begin
        pc_o <= pred_target_o;
      end
    end
  end

`ifdef BHT_EN
  logic [1:0]       bht_q [BHT_ENTRIES];
  logic [IDX_W-1:0] rd_idx;
  logic [IDX_W-1:0] upd_idx;
  logic             unused_upd_pc_bits;

  assign rd_idx             = pc_o[IDX_W+1:2];
  assign upd_idx            = upd_pc_i[IDX_W+1:2];
  assign unused_upd_pc_bits = ^{upd_pc_i[ADDR_WIDTH-1:IDX_W+2], upd_pc_i[1:0]};

  // Reads see the pre-edge counter, so a same-cycle update is not bypassed.
  assign pred_taken = btb_hit_i & bht_q[rd_idx][1];

  // NOTE: the counter array is reset element by element because every entry
  // must start weakly not-taken; this keeps it in flops rather than a RAM macro.
  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i) begin
      for (int i = 0; i < BHT_ENTRIES; i++) begin
        bht_q[i] <= 2'b01;
      end
    end else if (upd_en_i && !stall_fetch_i) begin
      if (upd_taken_i && (bht_q[upd_idx] != 2'b11)) begin
        bht_q[upd_idx] <= bht_q[upd_idx] + 2'b01;
      end else if (!upd_taken_i && (bht_q[upd_idx] != 2'b00)) begin
        bht_q[upd_idx] <= bht_q[upd_idx] - 2'b01;
      end
    end
  end
`else
  // The BTB only holds taken branches, so every hit is predicted taken.
  logic unused_upd;

  assign unused_upd = ^{upd_en_i, upd_pc_i, upd_taken_i};
  assign pred_taken = btb_hit_i;
`endif

endmodule

// File: tb/tb_fetch_pc_gen.sv
// Directed, table-driven bench for fetch_pc_gen; expectations follow the BHT_EN setting.
module tb_fetch_pc_gen;

`ifdef BHT_EN
  localparam bit BHT = 1'b1;
`else
  localparam bit BHT = 1'b0;
`endif

  logic        clk_i = 1'b0;
  logic        arst_i = 1'b1;
  logic        stall_fetch_i = 1'b0;
  logic        redirect_i = 1'b0;
  logic [63:0] redirect_addr_i = '0;
  logic        btb_hit_i = 1'b0;
  logic [63:0] btb_target_i = '0;
  logic [1:0]  btb_way_i = '0;
  logic        upd_en_i = 1'b0;
  logic [63:0] upd_pc_i = '0;
  logic        upd_taken_i = 1'b0;
  logic [63:0] pc_o;
  logic [63:0] pc_plus4_o;
  logic        fetch_valid_o;
  logic        pred_taken_o;
  logic [63:0] pred_target_o;
  logic [1:0]  pred_way_o;

  int checks = 0;
  int failures = 0;

  fetch_pc_gen dut (
    .clk_i           (clk_i),
    .arst_i          (arst_i),
    .stall_fetch_i   (stall_fetch_i),
    .redirect_i      (redirect_i),
    .redirect_addr_i (redirect_addr_i),
    .btb_hit_i       (btb_hit_i),
    .btb_target_i    (btb_target_i),
    .btb_way_i       (btb_way_i),
    .upd_en_i        (upd_en_i),
    .upd_pc_i        (upd_pc_i),
    .upd_taken_i     (upd_taken_i),
    .pc_o            (pc_o),
    .pc_plus4_o      (pc_plus4_o),
    .fetch_valid_o   (fetch_valid_o),
    .pred_taken_o    (pred_taken_o),
    .pred_target_o   (pred_target_o),
    .pred_way_o      (pred_way_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic        redirect;
    logic [63:0] redirect_addr;
    logic        stall;
    logic        hit;
    logic [63:0] target;
    logic [1:0]  way;
    logic        upd_en;
    logic [63:0] upd_pc;
    logic        upd_taken;
    logic [63:0] exp_pc;
    logic        exp_taken;
    logic [63:0] exp_ptarget;
    logic [63:0] exp_next;
  } vec_t;

  vec_t vecs[10];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic rd, input logic [63:0] rd_addr, input logic st,
                              input logic hit, input logic [63:0] tgt, input logic ue,
                              input logic [63:0] upc, input logic ut, input logic [63:0] epc,
                              input logic etk, input logic [63:0] ept, input logic [63:0] enx);
    vec_t v;
    v.redirect = rd;  v.redirect_addr = rd_addr; v.stall = st;
    v.hit = hit;      v.target = tgt;            v.way = tgt[5:4];
    v.upd_en = ue;    v.upd_pc = upc;            v.upd_taken = ut;
    v.exp_pc = epc;   v.exp_taken = etk;         v.exp_ptarget = ept;
    v.exp_next = enx;
    return v;
  endfunction

  // Drive on the falling edge, check the prediction, then check the PC after the rising edge.
  task automatic apply(input vec_t v, input string tag);
    @(negedge clk_i);
    redirect_i = v.redirect;   redirect_addr_i = v.redirect_addr;
    stall_fetch_i = v.stall;   btb_hit_i = v.hit;
    btb_target_i = v.target;   btb_way_i = v.way;
    upd_en_i = v.upd_en;       upd_pc_i = v.upd_pc;
    upd_taken_i = v.upd_taken;
    #1;
    check({tag, " pc"}, pc_o, v.exp_pc);
    check({tag, " pc_plus4"}, pc_plus4_o, v.exp_pc + 64'd4);
    check({tag, " pred_taken"}, 64'(pred_taken_o), 64'(v.exp_taken));
    check({tag, " pred_target"}, pred_target_o, v.exp_ptarget);
    check({tag, " pred_way"}, 64'(pred_way_o), 64'(v.way));
    check({tag, " fetch_valid"}, 64'(fetch_valid_o), 64'd1);
    @(posedge clk_i);
    #1;
    check({tag, " next_pc"}, pc_o, v.exp_next);
  endtask

  initial begin
    // Counter at index 0 (all multiples of 0x100) is driven 01->10->11->10->01->00.
    vecs[0] = mk(0, 0, 0, 1, 64'h400, 0, 0, 0, 64'hC, !BHT,
                 BHT ? 64'h10 : 64'h400, BHT ? 64'h10 : 64'h400);
    vecs[1] = mk(1, 64'h100, 0, 1, 64'h40, 1, 64'h100, 1, BHT ? 64'h10 : 64'h400, !BHT,
                 BHT ? 64'h14 : 64'h40, 64'h100);
    vecs[2] = mk(1, 64'h100, 0, 0, 64'h0, 1, 64'h100, 1, 64'h100, 0, 64'h104, 64'h100);
    vecs[3] = mk(0, 0, 0, 1, 64'h800, 0, 0, 0, 64'h100, 1, 64'h800, 64'h800);
    vecs[4] = mk(0, 0, 0, 1, 64'h900, 1, 64'h100, 0, 64'h800, 1, 64'h900, 64'h900);
    // Collision: counter 10 is being decremented; prediction must use the old value.
    vecs[5] = mk(0, 0, 0, 1, 64'hA00, 1, 64'h100, 0, 64'h900, 1, 64'hA00, 64'hA00);
    vecs[6] = mk(0, 0, 0, 0, 64'h0, 1, 64'h100, 0, 64'hA00, 0, 64'hA04, 64'hA04);
    vecs[7] = mk(1, 64'h100, 0, 0, 64'h0, 0, 0, 0, 64'hA04, 0, 64'hA08, 64'h100);
    vecs[8] = mk(0, 0, 0, 1, 64'h800, 0, 0, 0, 64'h100, !BHT,
                 BHT ? 64'h104 : 64'h800, BHT ? 64'h104 : 64'h800);
    vecs[9] = mk(1, 64'h3000, 0, 0, 64'h0, 0, 0, 0, BHT ? 64'h104 : 64'h800, 0,
                 BHT ? 64'h108 : 64'h804, 64'h3000);

    // Reset state
    #2;
    check("reset pc", pc_o, 64'h0);
    check("reset fetch_valid", 64'(fetch_valid_o), 64'd0);
    check("reset pc_plus4", pc_plus4_o, 64'h4);
    check("reset pred_taken", 64'(pred_taken_o), 64'd0);
    @(negedge clk_i);
    arst_i = 1'b0;
    #1;
    check("post-release pc", pc_o, 64'h0);
    check("post-release fetch_valid", 64'(fetch_valid_o), 64'd0);
    for (int k = 1; k <= 3; k++) begin
      @(posedge clk_i);
      #1;
      check($sformatf("seq pc step%0d", k), pc_o, 64'(4 * k));
      check($sformatf("seq fetch_valid step%0d", k), 64'(fetch_valid_o), 64'd1);
    end

    for (int i = 0; i < 10; i++) begin
      apply(vecs[i], $sformatf("vec%0d", i));
    end

    // Stall with pending updates: PC holds and the counter at 0x3000 stays 00.
    for (int i = 0; i < 4; i++) begin
      apply(mk(0, 0, 1, 0, 64'h0, 1, 64'h3000, 1, 64'h3000, 0, 64'h3004, 64'h3000),
            $sformatf("stall%0d", i));
    end
    apply(mk(1, 64'h2000, 1, 0, 64'h0, 1, 64'h3000, 1, 64'h3000, 0, 64'h3004, 64'h2000),
          "stall_redirect");
    apply(mk(0, 0, 0, 1, 64'h4000, 0, 0, 0, 64'h2000, !BHT,
             BHT ? 64'h2004 : 64'h4000, BHT ? 64'h2004 : 64'h4000), "post_stall_bht");

    // PC wrap at the top of the address space.
    apply(mk(1, 64'hFFFF_FFFF_FFFF_FFFC, 0, 0, 64'h0, 0, 0, 0, BHT ? 64'h2004 : 64'h4000, 0,
             BHT ? 64'h2008 : 64'h4004, 64'hFFFF_FFFF_FFFF_FFFC), "to_top");
    apply(mk(0, 0, 0, 0, 64'h0, 0, 0, 0, 64'hFFFF_FFFF_FFFF_FFFC, 0, 64'h0, 64'h0), "wrap");
    apply(mk(0, 0, 0, 0, 64'h0, 0, 0, 0, 64'h0, 0, 64'h4, 64'h4), "after_wrap");

    // Asynchronous reset mid-cycle, with a redirect pending.
    @(negedge clk_i);
    redirect_i = 1'b1;
    redirect_addr_i = 64'h5000;
    btb_hit_i = 1'b0;
    #2;
    arst_i = 1'b1;
    #1;
    check("async reset pc", pc_o, 64'h0);
    check("async reset fetch_valid", 64'(fetch_valid_o), 64'd0);
    @(posedge clk_i);
    #1;
    check("held reset pc", pc_o, 64'h0);
    @(negedge clk_i);
    redirect_i = 1'b0;
    arst_i = 1'b0;
    @(posedge clk_i);
    #1;
    check("re-release pc", pc_o, 64'h4);
    check("re-release fetch_valid", 64'(fetch_valid_o), 64'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
